// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences one FFT frame at a time around fft_process.
// It arms the core, strobes ADC samples at clk/SAMPLE_DIV while the core
// accepts data, tracks the largest in-band magnitude bin, and reports it.
// Optional watchdog: define FFT_FRAME_TIMEOUT_EN to abandon frames that do
// not reach REPORT within TIMEOUT_CYCLES clocks of ARM entry.
module fft_frame_ctrl #(
  parameter int SAMPLE_DIV     = 2,
  parameter int MIN_BIN        = 1,
  parameter int MAX_BIN        = 511,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  output logic        fft_enable,
  input  logic        fft_ready_for_data,
  output logic        adc_valid,
  input  logic [27:0] fft_mag,
  input  logic [9:0]  fft_bin,
  input  logic        fft_mag_valid,
  input  logic        fft_done,
  output logic [9:0]  peak_bin,
  output logic [27:0] peak_mag,
  output logic        result_valid,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, ARM, SAMPLE, COLLECT, REPORT} state_t;

  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [9:0] MIN_B    = 10'(MIN_BIN);
  localparam logic [9:0] MAX_B    = 10'(MAX_BIN);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [27:0] run_mag;
  logic [9:0]  run_bin;
  logic        collecting;
  logic        peak_hit;
  logic [27:0] nxt_mag;
  logic [9:0]  nxt_bin;
  logic        tmo_hit;

  // Strictly-greater compare means an equal magnitude later in the stream
  // never displaces the earlier (lower) bin.
  function automatic logic is_new_peak(input logic        vld,
                                       input logic [9:0]  bin,
                                       input logic [27:0] mag,
                                       input logic [27:0] cur);
    return vld && (bin >= MIN_B) && (bin <= MAX_B) && (mag > cur);
  endfunction

  assign collecting = (state == SAMPLE) || (state == COLLECT);
  assign peak_hit   = collecting && is_new_peak(fft_mag_valid, fft_bin, fft_mag, run_mag);
  assign nxt_mag    = peak_hit ? fft_mag : run_mag;
  assign nxt_bin    = peak_hit ? fft_bin : run_bin;

  // Running peak: cleared while armed, updated from the magnitude stream.
  always_ff @(posedge clk) begin
    if (state == ARM) begin
      run_mag <= '0;
      run_bin <= '0;
    end else if (peak_hit) begin
      run_mag <= fft_mag;
      run_bin <= fft_bin;
    end
  end

  // Frame sequencer with registered outputs; abort and watchdog win over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fft_enable   <= 1'b0;
      adc_valid    <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      div_cnt      <= '0;
      peak_bin     <= '0;
      peak_mag     <= '0;
      frame_count  <= '0;
    end else if (abort || tmo_hit) begin
      state        <= IDLE;
      fft_enable   <= 1'b0;
      adc_valid    <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      div_cnt      <= '0;
    end else begin
      result_valid <= 1'b0;
      adc_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ARM;
            fft_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ARM: begin
          div_cnt <= '0;
          if (fft_ready_for_data) state <= SAMPLE;
        end
        SAMPLE: begin
          if (!fft_ready_for_data) begin
            div_cnt <= '0;
            state   <= COLLECT;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            adc_valid <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        COLLECT: begin
          div_cnt <= '0;
          // Load from the next-peak value so a magnitude arriving with
          // fft_done is part of the reported result.
          if (fft_done) begin
            state        <= REPORT;
            fft_enable   <= 1'b0;
            result_valid <= 1'b1;
            peak_bin     <= nxt_bin;
            peak_mag     <= nxt_mag;
            frame_count  <= frame_count + 16'd1;
          end
        end
        REPORT: begin
          if (continuous) begin
            state      <= ARM;
            fft_enable <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          fft_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef FFT_FRAME_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tmo_cnt;

  assign tmo_hit = ((state == ARM) || collecting) && (tmo_cnt == TMO_LAST);

  // Watchdog: counts clocks from ARM entry; timeout_err is sticky until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (((state == IDLE) && start) || ((state == REPORT) && continuous))
        tmo_cnt <= '0;
      else if ((state == ARM) || collecting)
        tmo_cnt <= tmo_cnt + 32'd1;
      if ((state == IDLE) && start && !abort)
        timeout_err <= 1'b0;
      else if (tmo_hit && !abort)
        timeout_err <= 1'b1;
    end
  end
`else
  // Without the watchdog a frame waits forever; the limit is meaningless.
  logic tmo_cfg_unused;
  assign tmo_cfg_unused = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL provide parameter SAMPLE_DIV, default 2: clk cycles per adc_valid strobe (1 MHz / 2 = 500 kHz); legal range 1..255.
REQ-002 SHALL provide parameter MIN_BIN, default 1: lowest bin index included in the peak search (excludes DC).
REQ-003 SHALL provide parameter MAX_BIN, default 511: highest bin index included in the peak search (first Nyquist half of 1024).
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 20000: watchdog limit, counted in clk cycles from ARM entry.
REQ-005 SHALL provide port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port start  input  1  one-cycle request to run one frame.
REQ-008 SHALL provide port continuous  input  1  when high, re-arms automatically after each frame.
REQ-009 SHALL provide port abort  input  1  returns the block to IDLE from any state.
REQ-010 SHALL provide port fft_enable  output  1  drives fft_process enable.
REQ-011 SHALL provide port fft_ready_for_data  input  1  fft_process ready_for_data.
REQ-012 SHALL provide port adc_valid  output  1  sample strobe to fft_process.
REQ-013 SHALL provide ports fft_mag  input  28, fft_bin  input  10, fft_mag_valid  input  1  for the fft_process magnitude stream.
REQ-014 SHALL provide port fft_done  input  1  fft_process processing_done.
REQ-015 SHALL provide ports peak_bin  output  10, peak_mag  output  28  for the result of the last completed frame.
REQ-016 SHALL provide ports result_valid  output  1 (one-cycle pulse), busy  output  1, frame_count  output  16, timeout_err  output  1.

Function
REQ-017 SHALL implement states IDLE, ARM, SAMPLE, COLLECT, REPORT.
REQ-018 In IDLE, SHALL move to ARM when start=1; start SHALL be ignored in every other state.
REQ-019 In ARM, SHALL drive fft_enable=1, clear the internal peak registers to mag 0 / bin 0, and move to SAMPLE when fft_ready_for_data=1.
REQ-020 In SAMPLE, SHALL pulse adc_valid for one cycle every SAMPLE_DIV cycles; the first pulse comes SAMPLE_DIV cycles after ready is first seen high.
REQ-021 The divider SHALL reset to 0, with adc_valid=0, on any cycle where fft_ready_for_data=0.
REQ-022 SHALL move from SAMPLE to COLLECT when fft_ready_for_data falls, and SHALL hold adc_valid=0 outside SAMPLE.
REQ-023 In SAMPLE and COLLECT, on fft_mag_valid=1 with MIN_BIN<=fft_bin<=MAX_BIN and fft_mag strictly greater than the running peak, SHALL update the running peak; ties keep the lower bin.
REQ-024 In COLLECT, fft_done=1 SHALL move to REPORT; an fft_mag_valid arriving in the same cycle as fft_done SHALL still be included.
REQ-025 In REPORT (one cycle), SHALL drive fft_enable=0, load peak_bin/peak_mag from the running peak, pulse result_valid, and increment frame_count (wraps 0xFFFF to 0).
REQ-026 After REPORT, SHALL go to ARM if continuous=1 (giving one cycle of fft_enable=0 between frames), else to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 abort=1 SHALL force IDLE on the next edge, drive fft_enable=0, produce no result_valid, and leave peak_bin/peak_mag/frame_count unchanged; abort overrides start and every other event.
REQ-029 peak_bin/peak_mag SHALL change only in REPORT.

Reset
REQ-030 On rst_n=0, SHALL asynchronously force state IDLE and set fft_enable, adc_valid, result_valid, busy, timeout_err, peak_bin, peak_mag, frame_count and the divider to 0.
REQ-031 A reset asserted mid-frame SHALL discard the frame without emitting a result.

Configuration
REQ-032 With FFT_FRAME_TIMEOUT_EN defined, a cycle counter SHALL start at ARM entry; reaching TIMEOUT_CYCLES before REPORT SHALL force IDLE with fft_enable=0 and set sticky timeout_err=1, with no result_valid.
REQ-033 With FFT_FRAME_TIMEOUT_EN defined, timeout_err SHALL clear on the next accepted start; continuous re-arm SHALL NOT occur after a timeout.
REQ-034 Without FFT_FRAME_TIMEOUT_EN, SHALL instantiate no counter, SHALL tie timeout_err to 0, and a frame SHALL wait indefinitely.

Verification
REQ-035 60 kHz full-scale sine, fft_process model, start pulse, continuous=0 -> exactly one result_valid, peak_bin=123, frame_count=1, then IDLE with busy=0.
REQ-036 SAMPLE_DIV=2, ready held high for 2400 cycles -> exactly 1200 adc_valid pulses, spaced 2 cycles apart; a ready drop for 1 cycle -> divider restarts, with no pulse in that cycle or the next.
REQ-037 Stream with bin 0 mag 0xFFFFFFF, bins 40 and 90 both mag 0x100000, bin 600 mag 0x8000000 -> peak_bin=40, peak_mag=0x0100000.
REQ-038 continuous=1 for 3 frames -> three result_valid pulses, frame_count=3, and fft_enable low for exactly one cycle between frames.
REQ-039 abort asserted in COLLECT at bin 300 -> IDLE next cycle, no result_valid, previous peak_bin and frame_count retained; rst_n pulse mid-SAMPLE -> all outputs 0.
REQ-040 With FFT_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100, fft_ready_for_data held low -> timeout_err=1 at cycle 100 after ARM, then IDLE; the next start clears timeout_err.
